// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines, clear request and decoded key/digit outputs.
interface keypad_scanner_if;
    logic [3:0]  row;
    logic        clear;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] Data;
    modport master (output row, clear, input col, key_valid, key_code, Data);
    modport slave  (input row, clear, output col, key_valid, key_code, Data);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scanner with debounce and a 4-digit hex shift register.
// Define KEYPAD_REPEAT_EN to re-strobe a held key every REPEAT_SCANS dwell ends.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_SCANS   = 200
) (
    input logic             CLK_in,
    input logic             Reset,
    keypad_scanner_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    // one width covers both the confirm/release count and the repeat count
    localparam int CW = $clog2((DEBOUNCE_SCANS > REPEAT_SCANS ? DEBOUNCE_SCANS : REPEAT_SCANS) + 1);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
    state_t        r_state;
    logic [3:0]    r_sync, r_row_s, r_code;
    logic [DW-1:0] r_div;
    logic [1:0]    r_c, r_r;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic [15:0]   r_data;
    logic          w_dwell_end, w_hit, w_rep, w_strobe;
    logic [1:0]    w_low_r;
    logic [3:0]    w_code;
    logic [CW-1:0] w_cnt_nx;

    assign w_dwell_end = r_div == DW'(SCAN_DIV - 1);
    assign w_hit       = ~r_row_s[r_r];
    assign w_low_r     = ~r_row_s[0] ? 2'd0 : ~r_row_s[1] ? 2'd1 : ~r_row_s[2] ? 2'd2 : 2'd3;
    assign w_code      = {r_r, r_c};
    assign w_cnt_nx    = r_cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
    logic [CW-1:0] r_rep, w_rep_nx;
    assign w_rep_nx = r_rep + 1'b1;
    assign w_rep    = r_state == HELD && w_hit && w_rep_nx == CW'(REPEAT_SCANS);
    always_ff @(posedge CLK_in or posedge Reset)
        if (Reset) r_rep <= '0;
        else if (w_dwell_end) r_rep <= (r_state == HELD && w_hit && !w_rep) ? w_rep_nx : '0;
`else
    assign w_rep = 1'b0;
`endif
    assign w_strobe = w_dwell_end && (w_rep || (r_state == DEBOUNCE && w_hit && w_cnt_nx == CW'(DEBOUNCE_SCANS)));

    always_ff @(posedge CLK_in or posedge Reset) begin
        if (Reset) begin
            r_state <= SCAN;
            r_sync  <= 4'hF;
            r_row_s <= 4'hF;
            r_div   <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_code  <= 4'h0;
            r_data  <= 16'h0000;
        end else begin
            r_sync  <= bus.row;
            r_row_s <= r_sync;
            r_div   <= w_dwell_end ? '0 : r_div + 1'b1;
            r_valid <= w_strobe;
            if (w_strobe) begin
                r_code <= w_code;
                r_data <= {bus.clear ? 12'h000 : r_data[11:0], w_code};
            end else if (bus.clear) r_data <= 16'h0000;
            if (w_dwell_end) begin
                case (r_state)
                    SCAN: begin
                        if (r_row_s != 4'hF) begin
                            r_r     <= w_low_r;
                            r_cnt   <= '0;
                            r_state <= DEBOUNCE;
                        end else r_c <= r_c + 1'b1;
                    end
                    DEBOUNCE: begin
                        if (!w_hit) begin
                            r_state <= SCAN;
                            r_c     <= r_c + 1'b1;
                        end else if (w_cnt_nx == CW'(DEBOUNCE_SCANS)) begin
                            r_cnt   <= '0;
                            r_state <= HELD;
                        end else r_cnt <= w_cnt_nx;
                    end
                    HELD: begin
                        if (w_hit) r_cnt <= '0;
                        else if (w_cnt_nx == CW'(DEBOUNCE_SCANS)) begin
                            r_cnt   <= '0;
                            r_state <= SCAN;
                            r_c     <= r_c + 1'b1;
                        end else r_cnt <= w_cnt_nx;
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

    assign bus.col       = ~(4'b1000 >> r_c);
    assign bus.key_valid = r_valid;
    assign bus.key_code  = r_code;
    assign bus.Data      = r_data;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving keypad_scanner, checked against a press-level reference.
module tb_keypad_scanner;
    localparam int SD = 4, DEB = 3, REP = 5;
    logic CLK_in = 1'b0;
    logic Reset = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0] strobe_code = '0;
    logic prev_kv = 1'b0;
    int tests = 0, fails = 0, n_strobe = 0;
    int exp_q[$];

    keypad_scanner_if bus();
    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)) dut (
        .CLK_in(CLK_in), .Reset(Reset), .bus(bus)
    );

    always #5 CLK_in = ~CLK_in;

    // key index k = row*4 + column; column c is driven on col bit 3-c
    function automatic logic [3:0] keypad(input logic [3:0] col, input logic [15:0] p);
        logic [3:0] rows;
        rows = 4'hF;
        for (int k = 0; k < 16; k++) if (p[k] && !col[3 - (k % 4)]) rows[k / 4] = 1'b0;
        return rows;
    endfunction
    assign bus.row = keypad(bus.col, pressed);

    function automatic logic [3:0] colv(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[3 - c] = 1'b0;
        return v;
    endfunction

    function automatic logic [15:0] model_data();
        logic [15:0] d;
        d = '0;
        foreach (exp_q[i]) d = {d[11:0], 4'(exp_q[i])};
        return d;
    endfunction

    // Press starts at the first half-cycle of its column; dwell end k sees the row two edges late.
    function automatic int exp_strobes(input int h);
        int l;
        l = (h + 2) / SD;
        if (l < DEB + 1) return 0;
`ifdef KEYPAD_REPEAT_EN
        return 1 + (l - 1 - DEB) / REP;
`else
        return 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK_in) begin
        check("col_one_low", 32'($countones(~bus.col)), 32'd1);
        check("kv_single", {31'b0, prev_kv & bus.key_valid}, 32'd0);
        if (bus.key_valid) begin
            n_strobe++;
            strobe_code = bus.key_code;
        end
        prev_kv = bus.key_valid;
    end

    task automatic wait_col(input int c);
        logic [3:0] last;
        bit ok;
        last = bus.col;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLK_in);
            ok = bus.col == colv(c) && last != colv(c);
            last = bus.col;
        end
        check("wait_col", 32'(ok), 32'd1);
    endtask

    task automatic press(input logic [15:0] mask, input int c, input int h);
        wait_col(c);
        pressed = mask;
        repeat (h) @(negedge CLK_in);
        pressed = '0;
    endtask

    task automatic verify(input string tag, input int s0, input int n, input logic [3:0] code);
        check({tag, "_strobes"}, 32'(n_strobe - s0), 32'(n));
        if (n > 0) begin
            check({tag, "_strobe_code"}, 32'(strobe_code), 32'(code));
            check({tag, "_key_code"}, 32'(bus.key_code), 32'(code));
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(int'(code));
            if (exp_q.size() > 4) void'(exp_q.pop_front());
        end
        check({tag, "_data"}, 32'(bus.Data), 32'(model_data()));
    endtask

    task automatic run_key(input string tag, input logic [15:0] mask, input int c, input int h, input logic [3:0] code);
        int s0;
        s0 = n_strobe;
        press(mask, c, h);
        repeat (24) @(negedge CLK_in);
        verify(tag, s0, exp_strobes(h), code);
    endtask

    task automatic cycles_to_leave(input int c, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_in);
            n++;
            if (bus.col != colv(c)) break;
        end
    endtask

    initial begin
        int s0, n, code, r2, h;
        logic [15:0] mask;
        logic [3:0] exp_code;
        bus.clear = 1'b0;
        repeat (3) @(negedge CLK_in);
        check("rst_col", 32'(bus.col), 32'h7);
        check("rst_kv", 32'(bus.key_valid), 32'd0);
        check("rst_code", 32'(bus.key_code), 32'd0);
        check("rst_data", 32'(bus.Data), 32'd0);
        Reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK_in);
            check("idle_col", 32'(bus.col), 32'(colv((i / SD) % 4)));
        end
        check("idle_strobes", 32'(n_strobe), 32'd0);
        check("idle_data", 32'(bus.Data), 32'd0);

        s0 = n_strobe;
        press(16'(1 << 5), 1, 30);
        cycles_to_leave(1, n);
        check("k5_resume_col", 32'(bus.col), 32'(colv(2)));
        check("k5_resume_cycles", 32'(n), 32'(((30 + 2) / SD + DEB) * SD - 30));
        repeat (16) @(negedge CLK_in);
        verify("k5", s0, exp_strobes(30), 4'h5);
        check("k5_data_lit", 32'(bus.Data), 32'h0005);

        for (int k = 1; k <= 4; k++) run_key("seq", 16'(1 << k), k % 4, 20, 4'(k));
        check("seq_data_lit", 32'(bus.Data), 32'h1234);
        @(negedge CLK_in) bus.clear = 1'b1;
        @(negedge CLK_in) bus.clear = 1'b0;
        exp_q.delete();
        check("clr_data", 32'(bus.Data), 32'd0);
        check("clr_code", 32'(bus.key_code), 32'h4);

        run_key("rep", 16'(1 << 10), 2, 80, 4'hA);
`ifdef KEYPAD_REPEAT_EN
        check("rep_data_lit", 32'(bus.Data), 32'hAAAA);
`else
        check("rep_data_lit", 32'(bus.Data), 32'h000A);
`endif

        s0 = n_strobe;
        wait_col(3);
        pressed = 16'(1 << 7);
        repeat ((1 + DEB) * SD - 1) @(negedge CLK_in);
        bus.clear = 1'b1;
        @(negedge CLK_in) bus.clear = 1'b0;
        repeat (20 - (1 + DEB) * SD) @(negedge CLK_in);
        pressed = '0;
        repeat (24) @(negedge CLK_in);
        exp_q.delete();
        verify("clr_accept", s0, exp_strobes(20), 4'h7);

        s0 = n_strobe;
        press(16'(1 << 6), 2, 6);
        cycles_to_leave(2, n);
        check("bounce_col", 32'(bus.col), 32'(colv(3)));
        check("bounce_cycles", 32'(n), 32'(((6 + 2) / SD + 1) * SD - 6));
        repeat (16) @(negedge CLK_in);
        verify("bounce", s0, exp_strobes(6), 4'h0);

        for (int it = 0; it < 12; it++) begin
            code = $urandom_range(0, 15);
            mask = 16'(1 << code);
            exp_code = 4'(code);
            if ($urandom_range(0, 2) == 0) begin
                r2 = $urandom_range(0, 3);
                mask |= 16'(1 << (r2 * 4 + code % 4));
                exp_code = 4'(((code / 4 < r2) ? code / 4 : r2) * 4 + code % 4);
            end
            h = $urandom_range(1, 30);
            run_key("rand", mask, code % 4, h, exp_code);
        end

        s0 = n_strobe;
        wait_col(3);
        pressed = 16'((1 << 3) | (1 << 11));
        repeat (20) @(negedge CLK_in);
        check("dual_strobes", 32'(n_strobe - s0), 32'd1);
        check("dual_code", 32'(bus.key_code), 32'h3);
        #1 Reset = 1'b1;
        #1;
        check("midrst_col", 32'(bus.col), 32'h7);
        check("midrst_kv", 32'(bus.key_valid), 32'd0);
        check("midrst_code", 32'(bus.key_code), 32'd0);
        check("midrst_data", 32'(bus.Data), 32'd0);
        pressed = '0;
        repeat (3) @(negedge CLK_in);
        Reset = 1'b0;
        exp_q.delete();
        s0 = n_strobe;
        repeat (30) @(negedge CLK_in);
        check("post_rst_strobes", 32'(n_strobe - s0), 32'd0);
        check("post_rst_data", 32'(bus.Data), 32'(model_data()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
